mem_port_arbiter: RTL and testbench

- Shares one byte-addressed, word-accessed data memory between two requesters.
  - Port 0: instruction fetch.
  - Port 1: load/store unit.
- Sits between both requesters and the memory's mem_read/mem_write/address/data pins; drives those pins registered, one access at a time.
- Memory returns read data registered on the clock edge after the strobe.
- Fair round-robin arbitration, fixed per-transaction latency, alignment/range checking.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  localparam logic       PORT_IF           = 1'b0;
  localparam logic       PORT_LS           = 1'b1;
  localparam int         DEFAULT_MEM_BYTES = 512;
  localparam logic [1:0] ALIGN_MASK        = 2'b11;

  // Per-transaction control latched at grant time.
  typedef struct packed {
    logic port;
    logic we;
    logic illegal;
  } xact_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter; the pointer remembers the last granted port.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_vld,
  output logic       gnt_idx
);
  logic last;

  always_comb begin
    gnt_vld = |req;
    gnt_idx = req[1];
    if (req[0] && req[1]) gnt_idx = ~last;
  end

  // Reset to "port 1 granted last" so port 0 is preferred first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last <= PORT_LS;
    else if (en && gnt_vld)  last <= gnt_idx;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-accessed memory between instruction fetch (port 0) and
// load/store (port 1); fixed 4-cycle transactions, round-robin on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              err0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_e            state_q, state_d;
  xact_t             cur;
  logic              gnt_vld, gnt_idx;
  logic              sel_we, sel_illegal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, cap;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .en      (state_q == IDLE),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign sel_we      = gnt_idx ? we1    : we0;
  assign sel_addr    = gnt_idx ? addr1  : addr0;
  assign sel_wdata   = gnt_idx ? wdata1 : wdata0;
  assign sel_illegal = ((sel_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                       (sel_addr > ADDR_W'(MEM_BYTES - 4));
  // Writes and illegal accesses return zero read data.
  assign cap  = (cur.we || cur.illegal) ? '0 : mem_rdata;
  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      case (state_q)
        IDLE: if (gnt_vld) begin
          cur       <= '{port: gnt_idx, we: sel_we, illegal: sel_illegal};
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
          mem_read  <= !sel_we && !sel_illegal;
          mem_write <= sel_we && !sel_illegal;
        end
        WAIT: begin
          if (cur.port == PORT_IF) begin
            ack0   <= 1'b1;
            err0   <= cur.illegal;
            rdata0 <= cap;
          end else begin
            ack1   <= 1'b1;
            err1   <= cur.illegal;
            rdata1 <= cap;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-array memory model.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1, mem_read, mem_write, busy;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 0;
  logic [7:0]  mem [0:511];
  logic        mem_ready = 1'b0;
  int          nchk = 0, nerr = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory: preload on the first edge, then registered little-endian access.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem[0] <= 8'hAA; mem[1] <= 8'hFF; mem[2] <= 8'h00; mem[3] <= 8'hCC;
      mem[8] <= 8'h11; mem[9] <= 8'h22; mem[10] <= 8'h33; mem[11] <= 8'h44;
      mem[508] <= 8'h01; mem[509] <= 8'h02; mem[510] <= 8'h03; mem[511] <= 8'h04;
      mem_ready <= 1'b1;
    end else begin
      if (mem_read)
        mem_rdata <= {mem[mem_addr[8:0]+9'd3], mem[mem_addr[8:0]+9'd2],
                      mem[mem_addr[8:0]+9'd1], mem[mem_addr[8:0]]};
      if (mem_write) begin
        mem[mem_addr[8:0]]      <= mem_wdata[7:0];
        mem[mem_addr[8:0]+9'd1] <= mem_wdata[15:8];
        mem[mem_addr[8:0]+9'd2] <= mem_wdata[23:16];
        mem[mem_addr[8:0]+9'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One isolated transaction; samples on negedges E1..E4 after the request edge.
  task automatic xact(input logic port, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    if (port) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(negedge clk);
    chk("issue_rd", mem_read, !w && !exp_err);
    chk("issue_wr", mem_write, w && !exp_err);
    chk("issue_busy", busy, 1);
    if (!exp_err) chk("issue_addr", mem_addr, a);
    @(negedge clk);
    chk("wait_stb", {mem_read, mem_write}, 0);
    chk("wait_ack", {ack1, ack0}, 0);
    @(negedge clk);
    chk("ack", {ack1, ack0}, port ? 64'd2 : 64'd1);
    chk("err", port ? err1 : err0, exp_err);
    chk("rdata", port ? rdata1 : rdata0, exp_rd);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("ack_clr", {ack1, ack0}, 0);
    chk("idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, idle_cnt;
    // Both ports requesting from reset.
    req0 = 1; addr0 = 0; req1 = 1; addr1 = 8;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {ack0, ack1, err0, err1, mem_read, mem_write, busy}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_mem", {mem_addr, mem_wdata}, 0);
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      n = 0; idle_cnt = 0;
      do begin
        @(negedge clk); n++;
        if (!busy) idle_cnt++;
      end while (!(ack0 || ack1) && n < 12);
      chk("rr_order", {ack1, ack0}, (k % 2 == 1) ? 64'd2 : 64'd1);
      chk("rr_gap", n, (k == 0) ? 64'd3 : 64'd4);
      chk("rr_idle", idle_cnt, (k == 0) ? 64'd0 : 64'd1);
      chk("rr_rdata", (k % 2 == 1) ? rdata1 : rdata0,
          (k % 2 == 1) ? 64'h44332211 : 64'hCC00FFAA);
      if (k == 3) begin req0 = 0; req1 = 0; end
    end
    @(negedge clk);
    chk("rr_done", busy, 0);

    xact(0, 0, 32'd0, 32'd0, 32'hCC00FFAA, 0);
    xact(1, 1, 32'd8, 32'h5, 32'h0, 0);
    chk("wr_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'h05000000);
    xact(1, 0, 32'd8, 32'd0, 32'h5, 0);
    xact(0, 0, 32'd2, 32'd0, 32'h0, 1);
    xact(1, 0, 32'd510, 32'd0, 32'h0, 1);
    xact(1, 0, 32'd508, 32'd0, 32'h04030201, 0);
    xact(0, 1, 32'd512, 32'hDEAD, 32'h0, 1);

    // Reset during WAIT of a port 1 read.
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 8;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("arst_ctl", {ack0, ack1, err0, err1, mem_read, mem_write, busy}, 0);
    chk("arst_rdata", {rdata0, rdata1}, 0);
    req1 = 0;
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1 || mem_read || mem_write || busy) n++;
    end
    chk("arst_quiet", n, 0);
    req0 = 1; we0 = 0; addr0 = 0; req1 = 1; we1 = 0; addr1 = 8;
    repeat (3) @(negedge clk);
    chk("post_rst_pref", {ack1, ack0}, 1);
    chk("post_rst_rd0", rdata0, 32'hCC00FFAA);
    req0 = 0;
    repeat (4) @(negedge clk);
    chk("post_rst_ack1", {ack1, ack0}, 2);
    chk("post_rst_rd1", rdata1, 32'h5);
    req1 = 0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
